// File: rtl/branch_pred_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_unit
// Description : Direction predictor of 2-bit saturating counters.
//               Answers up to PEVAL_WIDTH lookups per cycle with zero latency,
//               returning a taken prediction and an exec_alt hint. The hint
//               marks weak counters so that the alternate path is fetched too.
//               The predictor trains from one resolved-branch feedback per
//               cycle. After reset an init sweep writes weak not-taken to
//               every entry. Lookups and updates stay disabled until the
//               sweep has finished.
//
// Ports       : clk, rst_n (async, active low)
//               req_valid/req_pc        per-lane lookup request
//               rsp_taken/rsp_exec_alt  per-lane prediction and weak hint
//               fb_valid/fb_base_pc/fb_taken  resolved-branch feedback
//               init_done               sweep complete, predictor live
//               fb_cnt/mispred_cnt      saturating event counters
//
// Options     : define BPU_GSHARE_EN to XOR a GHR_BITS global history
//               register into the table index (gshare).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_unit #(
    parameter int PEVAL_WIDTH = 2,
    parameter int IDX_BITS    = 8,
    parameter int GHR_BITS    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PEVAL_WIDTH-1:0]      req_valid,
    input  logic [PEVAL_WIDTH-1:0][31:0] req_pc,
    output logic [PEVAL_WIDTH-1:0]      rsp_taken,
    output logic [PEVAL_WIDTH-1:0]      rsp_exec_alt,
    input  logic                        fb_valid,
    input  logic [31:0]                 fb_base_pc,
    input  logic                        fb_taken,
    output logic                        init_done,
    output logic [31:0]                 fb_cnt,
    output logic [31:0]                 mispred_cnt
);

    localparam int         c_DEPTH   = 2**IDX_BITS;
    localparam bit         c_ALT_EN  = (PEVAL_WIDTH > 1);
    localparam logic [1:0] c_WEAK_NT = 2'b01;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_BITS-1:0] r_ptr;
    logic [1:0]          r_ctr [c_DEPTH];
    logic [31:0]         r_fb_cnt;
    logic [31:0]         r_mispred_cnt;

    logic                w_run;
    logic                w_fb_accept;
    logic [IDX_BITS-1:0] w_hist;
    logic [IDX_BITS-1:0] w_fb_idx;
    logic [1:0]          w_fb_ctr;
    logic [1:0]          w_fb_ctr_next;
    logic                w_fb_mispred;
    logic                w_unused_fb_pc;

    assign w_run       = (r_state == ST_RUN);
    assign w_fb_accept = w_run & fb_valid;

    // ------------------------------------------------------------------
    // Optional global history. The update index uses the pre-shift GHR
    // because the shift and the table write land on the same edge.
    // ------------------------------------------------------------------
`ifdef BPU_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (w_fb_accept) begin
            r_ghr <= {r_ghr[GHR_BITS-2:0], fb_taken};
        end
    end

    assign w_hist = IDX_BITS'(r_ghr);
`else
    assign w_hist = IDX_BITS'({GHR_BITS{1'b0}});
`endif

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (&r_ptr) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Feedback path: saturating counter update and misprediction detect
    // ------------------------------------------------------------------
    assign w_fb_idx       = fb_base_pc[IDX_BITS+1:2] ^ w_hist;
    assign w_fb_ctr       = r_ctr[w_fb_idx];
    assign w_fb_mispred   = fb_taken ^ w_fb_ctr[1];
    assign w_unused_fb_pc = ^{fb_base_pc[31:IDX_BITS+2], fb_base_pc[1:0]};

    always_comb begin
        w_fb_ctr_next = w_fb_ctr;
        if (fb_taken) begin
            if (w_fb_ctr != 2'b11) w_fb_ctr_next = w_fb_ctr + 2'b01;
        end else begin
            if (w_fb_ctr != 2'b00) w_fb_ctr_next = w_fb_ctr - 2'b01;
        end
    end

    // The table has no reset. The sweep initialises it, and while rst_n is
    // held low the sweep just keeps rewriting entry 0.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_ctr[r_ptr] <= c_WEAK_NT;
        end else if (w_fb_accept) begin
            r_ctr[w_fb_idx] <= w_fb_ctr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (w_fb_accept) begin
            if (r_fb_cnt != '1) begin
                r_fb_cnt <= r_fb_cnt + 32'd1;
            end
            if (w_fb_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup lanes: combinational reads without a write bypass, so a
    // colliding update becomes visible on the following cycle.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < PEVAL_WIDTH; g++) begin : g_lane
        logic [IDX_BITS-1:0] w_idx;
        logic [1:0]          w_ctr;
        logic                w_unused_pc;

        assign w_idx            = req_pc[g][IDX_BITS+1:2] ^ w_hist;
        assign w_ctr            = r_ctr[w_idx];
        assign rsp_taken[g]     = w_run & req_valid[g] & w_ctr[1];
        // Weak states (01, 10) are the ones where the two counter bits differ.
        assign rsp_exec_alt[g]  = w_run & req_valid[g] & c_ALT_EN & (w_ctr[1] ^ w_ctr[0]);
        assign w_unused_pc      = ^{req_pc[g][31:IDX_BITS+2], req_pc[g][1:0]};
    end

    assign init_done   = w_run;
    assign fb_cnt      = r_fb_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_pred_unit
// Description : Self-checking bench for branch_pred_unit in its default build
//               (gshare disabled). It applies a table of directed vectors,
//               then random traffic checked against a counter-array model.
//               It also covers the reset and init-sweep sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pred_unit;

    localparam int PW    = 2;
    localparam int IB    = 8;
    localparam int DEPTH = 2**IB;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [PW-1:0]        req_valid;
    logic [PW-1:0][31:0]  req_pc;
    logic [PW-1:0]        rsp_taken;
    logic [PW-1:0]        rsp_exec_alt;
    logic                 fb_valid;
    logic [31:0]          fb_base_pc;
    logic                 fb_taken;
    logic                 init_done;
    logic [31:0]          fb_cnt;
    logic [31:0]          mispred_cnt;

    branch_pred_unit #(.PEVAL_WIDTH(PW), .IDX_BITS(IB), .GHR_BITS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_pc       (req_pc),
        .rsp_taken    (rsp_taken),
        .rsp_exec_alt (rsp_exec_alt),
        .fb_valid     (fb_valid),
        .fb_base_pc   (fb_base_pc),
        .fb_taken     (fb_taken),
        .init_done    (init_done),
        .fb_cnt       (fb_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: one integer 0..3 per table entry plus event counts.
    int     m_ctr [DEPTH];
    longint m_fb;
    longint m_mis;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        fbv;
        logic [31:0] fpc;
        logic        ft;
        logic [1:0]  et;
        logic [1:0]  ea;
        int          efb;
        int          emis;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
        m_fb  = 0;
        m_mis = 0;
    endtask

    task automatic model_feedback(input logic [31:0] pc, input logic taken);
        int i;
        i = m_idx(pc);
        if ((m_ctr[i] >= 2) != taken) m_mis++;
        m_fb++;
        if (taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        else       m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] r;
        r      = $urandom;
        r[9:2] = 8'($urandom_range(0, 15));
        return r;
    endfunction

    // Counts edges from reset release until init_done rises; also watches
    // that no response leaks out while the sweep runs.
    task automatic wait_init(input string tag);
        int n;
        bit leak;
        n    = 0;
        leak = 1'b0;
        req_valid = '1;
        req_pc[0] = 32'h100;
        req_pc[1] = 32'h204;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (init_done) begin
                n = k;
                break;
            end
            if (rsp_taken != '0 || rsp_exec_alt != '0) leak = 1'b1;
        end
        check({tag, " init_cycles"}, n, 256);
        check({tag, " rsp_quiet_in_init"}, longint'(leak), 0);
        fb_valid  = 1'b0;
        req_valid = '0;
    endtask

    task automatic rand_phase(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int l = 0; l < PW; l++) begin
                req_valid[l] = 1'($urandom_range(0, 1));
                req_pc[l]    = pick_pc();
            end
            fb_valid   = ($urandom_range(0, 3) != 0);
            fb_base_pc = pick_pc();
            fb_taken   = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int l = 0; l < PW; l++) begin
                int e;
                e = m_ctr[m_idx(req_pc[l])];
                check({tag, " taken"}, longint'(rsp_taken[l]),
                      longint'(req_valid[l] && (e >= 2)));
                check({tag, " exec_alt"}, longint'(rsp_exec_alt[l]),
                      longint'(req_valid[l] && (PW > 1) && (e == 1 || e == 2)));
            end
            @(posedge clk); #1;
            if (fb_valid) model_feedback(fb_base_pc, fb_taken);
            check({tag, " fb_cnt"}, longint'(fb_cnt), m_fb);
            check({tag, " mispred_cnt"}, longint'(mispred_cnt), m_mis);
        end
        fb_valid  = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [13];
        vecs[0]  = '{2'b01, 32'h100, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b01, 0, 0};
        vecs[1]  = '{2'b11, 32'h200, 32'h600, 1'b1, 32'h200, 1'b1, 2'b00, 2'b11, 1, 1};
        vecs[2]  = '{2'b11, 32'h200, 32'h600, 1'b1, 32'h200, 1'b1, 2'b11, 2'b11, 2, 1};
        vecs[3]  = '{2'b11, 32'h200, 32'h600, 1'b1, 32'h200, 1'b1, 2'b11, 2'b00, 3, 1};
        vecs[4]  = '{2'b11, 32'h200, 32'h300, 1'b0, 32'h000, 1'b0, 2'b01, 2'b10, 3, 1};
        vecs[5]  = '{2'b00, 32'h200, 32'h300, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00, 3, 1};
        vecs[6]  = '{2'b10, 32'h300, 32'h200, 1'b1, 32'h200, 1'b0, 2'b10, 2'b00, 4, 2};
        vecs[7]  = '{2'b11, 32'h200, 32'h203, 1'b1, 32'h200, 1'b0, 2'b11, 2'b11, 5, 3};
        vecs[8]  = '{2'b01, 32'h200, 32'h000, 1'b1, 32'h200, 1'b0, 2'b00, 2'b01, 6, 3};
        vecs[9]  = '{2'b01, 32'h600, 32'h000, 1'b1, 32'h200, 1'b0, 2'b00, 2'b00, 7, 3};
        vecs[10] = '{2'b01, 32'h200, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00, 7, 3};
        vecs[11] = '{2'b01, 32'h000, 32'h000, 1'b1, 32'h400, 1'b1, 2'b00, 2'b01, 8, 4};
        vecs[12] = '{2'b11, 32'h400, 32'h100, 1'b0, 32'h000, 1'b0, 2'b01, 2'b11, 8, 4};

        // Reset state
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_pc[0]  = 32'h100;
        req_pc[1]  = 32'h200;
        fb_valid   = 1'b0;
        fb_base_pc = '0;
        fb_taken   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset init_done", longint'(init_done), 0);
        check("reset fb_cnt", longint'(fb_cnt), 0);
        check("reset mispred_cnt", longint'(mispred_cnt), 0);
        check("reset rsp_taken", longint'(rsp_taken), 0);
        check("reset rsp_exec_alt", longint'(rsp_exec_alt), 0);

        // Release reset with feedback held active during the sweep
        @(negedge clk);
        rst_n      = 1'b1;
        fb_valid   = 1'b1;
        fb_base_pc = 32'h100;
        fb_taken   = 1'b1;
        wait_init("boot");
        check("boot fb_cnt", longint'(fb_cnt), 0);
        model_reset();

        // Directed vectors
        for (int v = 0; v < 13; v++) begin
            req_valid  = vecs[v].rv;
            req_pc[0]  = vecs[v].pc0;
            req_pc[1]  = vecs[v].pc1;
            fb_valid   = vecs[v].fbv;
            fb_base_pc = vecs[v].fpc;
            fb_taken   = vecs[v].ft;
            @(negedge clk);
            check($sformatf("vec%0d rsp_taken", v), longint'(rsp_taken), longint'(vecs[v].et));
            check($sformatf("vec%0d rsp_exec_alt", v), longint'(rsp_exec_alt), longint'(vecs[v].ea));
            @(posedge clk); #1;
            if (vecs[v].fbv) model_feedback(vecs[v].fpc, vecs[v].ft);
            check($sformatf("vec%0d fb_cnt", v), longint'(fb_cnt), longint'(vecs[v].efb));
            check($sformatf("vec%0d mispred_cnt", v), longint'(mispred_cnt), longint'(vecs[v].emis));
        end
        fb_valid  = 1'b0;
        req_valid = '0;

        rand_phase("rand1", 400);

        // Mid-RUN asynchronous reset pulse
        req_valid = 2'b11;
        req_pc[0] = 32'h200;
        req_pc[1] = 32'h400;
        rst_n     = 1'b0;
        #1;
        check("midrun init_done", longint'(init_done), 0);
        check("midrun fb_cnt", longint'(fb_cnt), 0);
        check("midrun mispred_cnt", longint'(mispred_cnt), 0);
        check("midrun rsp_taken", longint'(rsp_taken), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("rerun");
        model_reset();

        req_valid = 2'b11;
        req_pc[0] = 32'h200;
        req_pc[1] = 32'h400;
        @(negedge clk);
        check("rerun rsp_taken", longint'(rsp_taken), 0);
        check("rerun rsp_exec_alt", longint'(rsp_exec_alt), 3);
        @(posedge clk); #1;
        req_valid = '0;

        rand_phase("rand2", 150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
